csr_row_sequencer: RTL and testbench

Walks a CSR-encoded sparse weight matrix row by row. It reads per-row start pointers from a row-pointer memory, then issues one weight-memory address per nonzero. The returned {index, weight} pairs go out on a valid/ready stream, tagged with the row number and an end-of-row flag. It sits between the weight memory and the neuron-update datapath and is the only master of the weight-memory address port.

---
 rtl/csr_seq_pkg.sv | 41 ++++
 rtl/csr_row_sequencer_if.sv | 39 +++
 rtl/csr_skid_fifo.sv | 54 +++++
 rtl/csr_row_sequencer.sv | 129 ++++++++++++
 tb/tb_csr_row_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_seq_pkg.sv
// Shared types for the CSR row sequencer: FSM states, in-flight tag and output beat.
package csr_seq_pkg;

  localparam int CSR_N_ROWS = 40;
  localparam int CSR_ADDR_W = 14;
  localparam int CSR_ROW_W  = 6;
  localparam int WEIGHT_W   = 8;
  localparam int INDEX_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_P0,
    S_WT_P0,
    S_RD_PN,
    S_WT_PN,
    S_STREAM,
    S_EMPTY,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [CSR_ROW_W-1:0] row;
    logic                 last;
    logic                 empty;
  } tag_t;

  typedef struct packed {
    tag_t                tag;
    logic [WEIGHT_W-1:0] weight;
    logic [INDEX_W-1:0]  index;
  } beat_t;

  // At most two beats may be owned downstream (FIFO + in-flight); a same-cycle pop frees one.
  function automatic logic can_issue(input logic [1:0] fifo_count, input logic inflight,
                                     input logic pop);
    logic [1:0] used;
    used = fifo_count + {1'b0, inflight};
    return (used <= 2'd1) || ((used == 2'd2) && pop);
  endfunction

endpackage

// File: rtl/csr_row_sequencer_if.sv
// Bus bundle for the CSR row sequencer: control, row-pointer and weight memories, output stream.
interface csr_row_sequencer_if
  import csr_seq_pkg::*;
#(
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int ROW_W  = CSR_ROW_W
);
  logic                start;
  logic                busy;
  logic                done;
  logic                err;
  logic [ROW_W-1:0]    rowptr_addr;
  logic [ADDR_W:0]     rowptr_data;
  logic [ADDR_W-1:0]   w_addr;
  logic [WEIGHT_W-1:0] w_weight;
  logic [INDEX_W-1:0]  w_index;
  // Stream: a beat transfers on a cycle with out_valid & out_ready; while out_valid is high
  // and out_ready low, every out_* field holds its value.
  logic                out_valid;
  logic                out_ready;
  logic [WEIGHT_W-1:0] out_weight;
  logic [INDEX_W-1:0]  out_index;
  logic [ROW_W-1:0]    out_row;
  logic                out_last;
  logic                out_empty;
  state_e              dbg_state;

  modport master (
    input  start, rowptr_data, w_weight, w_index, out_ready,
    output busy, done, err, rowptr_addr, w_addr,
           out_valid, out_weight, out_index, out_row, out_last, out_empty, dbg_state
  );

  modport slave (
    output start, rowptr_data, w_weight, w_index, out_ready,
    input  busy, done, err, rowptr_addr, w_addr,
           out_valid, out_weight, out_index, out_row, out_last, out_empty, dbg_state
  );
endinterface

// File: rtl/csr_skid_fifo.sv
// Two-entry FIFO of output beats; entry 0 is the registered head seen on the stream.
module csr_skid_fifo
  import csr_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  beat_t      push_data_i,
  input  logic       pop_i,
  output beat_t      head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);
  beat_t      ent0_q, ent1_q;
  logic [1:0] count_q;
  logic       do_pop, do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_data_i;
          else                 ent1_q <= push_data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= push_data_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = ent0_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/csr_row_sequencer.sv
// Sweeps all CSR rows: fetches row pointers, issues one weight address per nonzero,
// and streams tagged {index, weight} beats through a 2-entry FIFO.
module csr_row_sequencer
  import csr_seq_pkg::*;
#(
  parameter int N_ROWS = CSR_N_ROWS,
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int ROW_W  = CSR_ROW_W
) (
  input logic                 clk,
  input logic                 rst,
  csr_row_sequencer_if.master bus
);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  state_e           state_q;
  logic [ROW_W-1:0] row_q, rowptr_addr_q;
  logic [ADDR_W:0]  cur_q, end_q, cur_inc;
  logic             busy_q, done_q, err_q;
  logic             infl_valid_q;
  tag_t             infl_tag_q, issue_tag;
  beat_t            push_beat, head_beat;
  logic [1:0]       fifo_count;
  logic             fifo_valid, pop, issue, row_done, drain_done;

  assign pop      = fifo_valid & bus.out_ready;
  assign issue    = ((state_q == S_STREAM) || (state_q == S_EMPTY))
                    && can_issue(fifo_count, infl_valid_q, pop);
  assign cur_inc  = cur_q + (ADDR_W+1)'(1);
  assign row_done = issue && ((state_q == S_EMPTY) || (cur_inc == end_q));
  assign drain_done = (state_q == S_DRAIN) && !infl_valid_q
                      && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  assign issue_tag.row   = row_q;
  assign issue_tag.last  = row_done;
  assign issue_tag.empty = (state_q == S_EMPTY);

  // Memory data belongs to the address issued one cycle earlier; empty slots carry zeros.
  assign push_beat.tag    = infl_tag_q;
  assign push_beat.weight = infl_tag_q.empty ? '0 : bus.w_weight;
  assign push_beat.index  = infl_tag_q.empty ? '0 : bus.w_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      rowptr_addr_q <= '0;
      cur_q         <= '0;
      end_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      infl_valid_q  <= 1'b0;
      infl_tag_q    <= '0;
    end else begin
      done_q       <= 1'b0;
      infl_valid_q <= issue;
      if (issue) infl_tag_q <= issue_tag;
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q       <= S_RD_P0;
          row_q         <= '0;
          rowptr_addr_q <= '0;
          busy_q        <= 1'b1;
          err_q         <= 1'b0;
        end
        S_RD_P0: state_q <= S_WT_P0;
        S_WT_P0: begin
          cur_q         <= bus.rowptr_data;
          rowptr_addr_q <= row_q + ROW_W'(1);
          state_q       <= S_RD_PN;
        end
        S_RD_PN: state_q <= S_WT_PN;
        // A decreasing pointer flags err and the row is emitted empty; cur stays put.
        S_WT_PN: begin
          end_q <= bus.rowptr_data;
          if (bus.rowptr_data > cur_q) begin
            state_q <= S_STREAM;
          end else begin
            state_q <= S_EMPTY;
            if (bus.rowptr_data < cur_q) err_q <= 1'b1;
          end
        end
        S_STREAM: if (issue) cur_q <= cur_inc;
        S_EMPTY:  ;
        S_DRAIN: if (drain_done) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (row_done) begin
        if (row_q == LAST_ROW) begin
          state_q <= S_DRAIN;
        end else begin
          row_q         <= row_q + ROW_W'(1);
          rowptr_addr_q <= row_q + ROW_W'(2);
          state_q       <= S_RD_PN;
        end
      end
    end
  end

  csr_skid_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (infl_valid_q),
    .push_data_i(push_beat),
    .pop_i      (pop),
    .head_o     (head_beat),
    .valid_o    (fifo_valid),
    .count_o    (fifo_count)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.rowptr_addr = rowptr_addr_q;
  assign bus.w_addr      = cur_q[ADDR_W-1:0];
  assign bus.out_valid   = fifo_valid;
  assign bus.out_weight  = head_beat.weight;
  assign bus.out_index   = head_beat.index;
  assign bus.out_row     = head_beat.tag.row;
  assign bus.out_last    = head_beat.tag.last;
  assign bus.out_empty   = head_beat.tag.empty;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_csr_row_sequencer.sv
// Directed bench for csr_row_sequencer with a 3-row matrix, sync memory models and a beat scoreboard.
module tb_csr_row_sequencer;
  import csr_seq_pkg::*;

  localparam int N_ROWS = 3;
  localparam int ADDR_W = 14;
  localparam int ROW_W  = 6;
  localparam int BW     = ROW_W + 2 + WEIGHT_W + INDEX_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_row_sequencer_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus ();

  csr_row_sequencer #(.N_ROWS(N_ROWS), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int beats_seen = 0;
  int done_seen = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int ready_mode = 0;
  logic [BW-1:0] exp_q[$];
  logic [ADDR_W:0] ptr_mem [0:63];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[13:10], ~a[3:0], a[9:0]};
  endfunction

  function automatic logic [BW-1:0] obs_beat();
    return {bus.out_row, bus.out_last, bus.out_empty, bus.out_weight, bus.out_index};
  endfunction

  // ---------------- memory models ----------------
  always @(posedge clk) begin
    bus.rowptr_data <= ptr_mem[bus.rowptr_addr];
    {bus.w_weight, bus.w_index} <= mem_word(bus.w_addr);
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) bus.out_ready = 1'b1;
      else                 bus.out_ready = ~bus.out_ready;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic          hold_v;
    logic [BW-1:0] hold_b;
    hold_v = 1'b0;
    hold_b = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check_eq("stall_valid", 32'(bus.out_valid), 1);
          check_eq("stall_data", 32'(obs_beat()), 32'(hold_b));
          hold_v = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          check_eq("beat_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check_eq("beat", 32'(obs_beat()), 32'(exp_q.pop_front()));
          beats_seen++;
          last_hs_cyc = cyc;
        end else if (bus.out_valid) begin
          hold_v = 1'b1;
          hold_b = obs_beat();
        end
        if (bus.done) begin
          done_seen++;
          done_cyc = cyc;
          check_eq("busy_at_done", 32'(bus.busy), 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ptrs(input int p0, input int p1, input int p2, input int p3);
    ptr_mem[0] = (ADDR_W+1)'(p0);
    ptr_mem[1] = (ADDR_W+1)'(p1);
    ptr_mem[2] = (ADDR_W+1)'(p2);
    ptr_mem[3] = (ADDR_W+1)'(p3);
  endtask

  task automatic push_exp(input int row, input logic last, input logic empty, input int addr);
    logic [17:0] d;
    d = empty ? 18'd0 : mem_word(ADDR_W'(addr));
    exp_q.push_back({ROW_W'(row), last, empty, d});
  endtask

  task automatic push_row(input int row, input int first, input int nnz);
    if (nnz == 0) push_exp(row, 1'b1, 1'b1, 0);
    else for (int a = first; a < first + nnz; a++) push_exp(row, a == first + nnz - 1, 1'b0, a);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0, input string tag);
    int n;
    n = 0;
    while (done_seen == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_done_once"}, 32'(done_seen - d0), 1);
    check_eq({tag, "_done_after_last"}, 32'(done_cyc - last_hs_cyc), 1);
    check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0, d0;
    rst = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 64; i++) ptr_mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_err", 32'(bus.err), 0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_last_empty", 32'({bus.out_last, bus.out_empty}), 0);
    check_eq("rst_rowptr_addr", 32'(bus.rowptr_addr), 0);
    check_eq("rst_w_addr", 32'(bus.w_addr), 0);
    check_eq("rst_out_data", 32'(obs_beat()), 0);
    check_eq("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;

    // A: ptr {0,2,2,5}, ready high, with cycle-accurate startup latency
    set_ptrs(0, 2, 2, 5);
    push_row(0, 0, 2);
    push_row(1, 2, 0);
    push_row(2, 2, 3);
    b0 = beats_seen;
    d0 = done_seen;
    pulse_start();
    @(negedge clk);
    check_eq("a_c1_rowptr_addr", 32'(bus.rowptr_addr), 0);
    check_eq("a_c1_busy", 32'(bus.busy), 1);
    check_eq("a_c1_state", 32'(bus.dbg_state), 32'(S_RD_P0));
    @(negedge clk);
    check_eq("a_c2_state", 32'(bus.dbg_state), 32'(S_WT_P0));
    @(negedge clk);
    check_eq("a_c3_rowptr_addr", 32'(bus.rowptr_addr), 1);
    @(negedge clk);
    check_eq("a_c4_state", 32'(bus.dbg_state), 32'(S_WT_PN));
    @(negedge clk);
    check_eq("a_c5_state", 32'(bus.dbg_state), 32'(S_STREAM));
    check_eq("a_c5_w_addr", 32'(bus.w_addr), 0);
    @(negedge clk);
    check_eq("a_c6_out_valid", 32'(bus.out_valid), 0);
    check_eq("a_c6_w_addr", 32'(bus.w_addr), 1);
    @(negedge clk);
    check_eq("a_c7_out_valid", 32'(bus.out_valid), 1);
    wait_done(200, d0, "a");
    check_eq("a_beats", 32'(beats_seen - b0), 6);
    check_eq("a_err", 32'(bus.err), 0);

    // B: same matrix, out_ready toggling every cycle
    ready_mode = 1;
    push_row(0, 0, 2);
    push_row(1, 2, 0);
    push_row(2, 2, 3);
    b0 = beats_seen;
    d0 = done_seen;
    pulse_start();
    wait_done(400, d0, "b");
    check_eq("b_beats", 32'(beats_seen - b0), 6);
    ready_mode = 0;
    repeat (2) @(posedge clk);

    // C: decreasing pointer sets err, row 1 empty, row 2 continues from 4
    set_ptrs(0, 4, 3, 6);
    push_row(0, 0, 4);
    push_row(1, 0, 0);
    push_row(2, 4, 2);
    b0 = beats_seen;
    d0 = done_seen;
    pulse_start();
    wait_done(200, d0, "c");
    check_eq("c_beats", 32'(beats_seen - b0), 7);
    check_eq("c_err", 32'(bus.err), 1);

    // D: full 2**ADDR_W nonzeros in row 0; start clears err
    set_ptrs(0, 16384, 16384, 16384);
    push_row(0, 0, 16384);
    push_row(1, 0, 0);
    push_row(2, 0, 0);
    b0 = beats_seen;
    d0 = done_seen;
    pulse_start();
    @(negedge clk);
    check_eq("d_err_cleared", 32'(bus.err), 0);
    wait_done(20000, d0, "d");
    check_eq("d_beats", 32'(beats_seen - b0), 16386);
    check_eq("d_err", 32'(bus.err), 0);

    // E: reset in the middle of row 1, then a clean restart
    set_ptrs(0, 3, 8, 9);
    push_row(0, 0, 3);
    push_row(1, 3, 5);
    push_row(2, 8, 1);
    d0 = done_seen;
    pulse_start();
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("e_rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("e_rst_busy", 32'(bus.busy), 0);
    check_eq("e_rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    repeat (3) @(negedge clk);
    check_eq("e_no_done_on_rst", 32'(done_seen - d0), 0);
    push_row(0, 0, 3);
    push_row(1, 3, 5);
    push_row(2, 8, 1);
    b0 = beats_seen;
    pulse_start();
    wait_done(200, d0, "e");
    check_eq("e_beats", 32'(beats_seen - b0), 9);

    // F: start pulses while busy are ignored
    set_ptrs(0, 2, 2, 5);
    push_row(0, 0, 2);
    push_row(1, 2, 0);
    push_row(2, 2, 3);
    b0 = beats_seen;
    d0 = done_seen;
    pulse_start();
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    wait_done(200, d0, "f");
    repeat (20) @(negedge clk);
    check_eq("f_beats", 32'(beats_seen - b0), 6);
    check_eq("f_done_count", 32'(done_seen - d0), 1);
    check_eq("f_idle_busy", 32'(bus.busy), 0);
    check_eq("f_idle_state", 32'(bus.dbg_state), 32'(S_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
